// File: rtl/ram_sp_be_init.sv
// rtl/ram_sp_be_init.sv - single-port RAM with byte-lane writes, registered read and clear engine
module ram_sp_be_init #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 8,
    parameter int                READ_MODE = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout,
    output logic                  dout_valid,
    output logic                  ready
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] new_word;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Merge enabled byte lanes of din over the currently stored word.
    always_comb begin
        old_word = mem[addr];
        new_word = old_word;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                new_word[8*i +: 8] = din[8*i +: 8];
            end
        end
    end

    // Single write port shared by the clear engine and user writes; rst/init block both.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = new_word;
        if (!rst && !init) begin
            if (state == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr;
                mem_wdata = CLEAR_VAL;
            end else if (en && we) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_CLEAR;
            clr_addr   <= '0;
            ready      <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (init) begin
            state      <= ST_CLEAR;
            clr_addr   <= '0;
            ready      <= 1'b0;
            dout_valid <= 1'b0;
        end else if (state == ST_CLEAR) begin
            clr_addr   <= clr_addr + 1'b1;
            dout_valid <= 1'b0;
            if (&clr_addr) begin
                state <= ST_RUN;
                ready <= 1'b1;
            end
        end else if (en) begin
            dout_valid <= 1'b1;
            if (we && (READ_MODE == 0)) begin
                dout <= new_word;
            end else begin
                dout <= old_word;
            end
        end else begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_sp_be_init.sv
// tb/tb_ram_sp_be_init.sv - scoreboard bench for ram_sp_be_init in three configurations
module tb_ram_sp_be_init;

    logic        clk;
    logic        rst, init, en, we;
    logic [1:0]  be;
    logic [7:0]  addr;
    logic [15:0] din;
    logic [15:0] dout0, dout1;
    logic        dv0, dv1, rdy0, rdy1;

    logic        rst2, init2, en2, we2;
    logic [3:0]  be2;
    logic [3:0]  addr2;
    logic [31:0] din2;
    logic [31:0] dout2;
    logic        dv2, rdy2;

    int checks = 0;
    int failures = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [31:0] q2[$];

    ram_sp_be_init u0 (
        .clk(clk), .rst(rst), .init(init), .en(en), .we(we), .be(be),
        .addr(addr), .din(din), .dout(dout0), .dout_valid(dv0), .ready(rdy0)
    );

    ram_sp_be_init #(.READ_MODE(1), .CLEAR_VAL(16'hDEAD)) u1 (
        .clk(clk), .rst(rst), .init(init), .en(en), .we(we), .be(be),
        .addr(addr), .din(din), .dout(dout1), .dout_valid(dv1), .ready(rdy1)
    );

    ram_sp_be_init #(.DATA_W(32), .ADDR_W(4)) u2 (
        .clk(clk), .rst(rst2), .init(init2), .en(en2), .we(we2), .be(be2),
        .addr(addr2), .din(din2), .dout(dout2), .dout_valid(dv2), .ready(rdy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitors: every valid output pops and compares the oldest expectation.
    always @(negedge clk) begin
        if (dv0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++; failures++;
                $display("FAIL u0_unexpected_valid actual=%h required=no_valid", dout0);
            end else chk("u0_dout", {16'h0, dout0}, {16'h0, q0.pop_front()});
        end
        if (dv1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL u1_unexpected_valid actual=%h required=no_valid", dout1);
            end else chk("u1_dout", {16'h0, dout1}, {16'h0, q1.pop_front()});
        end
        if (dv2 === 1'b1) begin
            if (q2.size() == 0) begin
                checks++; failures++;
                $display("FAIL u2_unexpected_valid actual=%h required=no_valid", dout2);
            end else chk("u2_dout", dout2, q2.pop_front());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input logic w, input logic [1:0] b, input logic [7:0] a,
                       input logic [15:0] d, input logic [15:0] x0, input logic [15:0] x1);
        en = 1'b1; we = w; be = b; addr = a; din = d;
        q0.push_back(x0);
        q1.push_back(x1);
        cyc();
        en = 1'b0;
    endtask

    task automatic acc2(input logic w, input logic [3:0] b, input logic [3:0] a,
                        input logic [31:0] d, input logic [31:0] x);
        en2 = 1'b1; we2 = w; be2 = b; addr2 = a; din2 = d;
        q2.push_back(x);
        cyc();
        en2 = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int edges);
        int r0;
        int r1;
        r0 = 0;
        r1 = 0;
        for (int k = 1; k <= edges + 20; k++) begin
            cyc();
            if (rdy0 === 1'b1 && r0 == 0) r0 = k;
            if (rdy1 === 1'b1 && r1 == 0) r1 = k;
            if (r0 != 0 && r1 != 0) break;
        end
        chk({name, "_u0_ready_edges"}, r0, edges);
        chk({name, "_u1_ready_edges"}, r1, edges);
    endtask

    initial begin
        int r2;
        rst = 1'b1; init = 1'b0; en = 1'b0; we = 1'b0; be = 2'b00; addr = 8'h00; din = 16'h0000;
        rst2 = 1'b1; init2 = 1'b0; en2 = 1'b0; we2 = 1'b0; be2 = 4'h0; addr2 = 4'h0; din2 = 32'h0;
        cyc();
        cyc();
        chk("rst_u0_ready", rdy0, 0);
        chk("rst_u0_valid", dv0, 0);
        chk("rst_u0_dout", dout0, 0);
        chk("rst_u1_ready", rdy1, 0);
        chk("rst_u1_dout", dout1, 0);

        // Power-up clear, then read the top address
        rst = 1'b0;
        wait_ready("powerup", 256);
        acc(1'b0, 2'b00, 8'hFF, 16'h0000, 16'h0000, 16'hDEAD);

        // Full write, then byte-lane merges in both read-during-write modes
        acc(1'b1, 2'b11, 8'h10, 16'hABCD, 16'hABCD, 16'hDEAD);
        acc(1'b0, 2'b00, 8'h10, 16'h0000, 16'hABCD, 16'hABCD);
        acc(1'b1, 2'b01, 8'h10, 16'h1234, 16'hAB34, 16'hABCD);
        acc(1'b0, 2'b00, 8'h10, 16'h0000, 16'hAB34, 16'hAB34);
        acc(1'b1, 2'b00, 8'h10, 16'hFFFF, 16'hAB34, 16'hAB34);
        acc(1'b0, 2'b00, 8'h10, 16'h0000, 16'hAB34, 16'hAB34);

        // Idle cycles: valid drops, data holds
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("idle_u0_valid", dv0, 0);
            chk("idle_u0_dout", dout0, 16'hAB34);
            chk("idle_u1_dout", dout1, 16'hAB34);
        end

        // init with a colliding write; accesses during the clear are ignored
        init = 1'b1; en = 1'b1; we = 1'b1; be = 2'b11; addr = 8'h20; din = 16'h5555;
        cyc();
        init = 1'b0;
        chk("init_u0_ready", rdy0, 0);
        din = 16'h7777;
        wait_ready("init", 256);
        en = 1'b0;
        acc(1'b0, 2'b00, 8'h10, 16'h0000, 16'h0000, 16'hDEAD);
        acc(1'b0, 2'b00, 8'h20, 16'h0000, 16'h0000, 16'hDEAD);

        // rst in the middle of a clear restarts it from address 0
        init = 1'b1;
        cyc();
        init = 1'b0;
        repeat (100) cyc();
        chk("midclr_u1_dout_held", dout1, 16'hDEAD);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midclr_u1_dout_reset", dout1, 0);
        chk("midclr_u1_ready", rdy1, 0);
        wait_ready("midclr", 256);
        acc(1'b0, 2'b00, 8'h20, 16'h0000, 16'h0000, 16'hDEAD);

        // 32-bit wide, 16-deep configuration
        cyc();
        rst2 = 1'b0;
        r2 = 0;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (rdy2 === 1'b1) begin
                r2 = k;
                break;
            end
        end
        chk("u2_ready_edges", r2, 16);
        acc2(1'b1, 4'b1010, 4'h3, 32'h11223344, 32'h11003300);
        acc2(1'b0, 4'b0000, 4'h3, 32'h0, 32'h11003300);
        acc2(1'b1, 4'b0101, 4'h3, 32'hAABBCCDD, 32'h11BB33DD);
        acc2(1'b0, 4'b0000, 4'h3, 32'h0, 32'h11BB33DD);

        repeat (3) cyc();
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
